axis_complex_averager_ema: RTL and testbench



---
 rtl/axis_complex_averager_ema.sv | 186 ++++++++++++++++++
 tb/tb_axis_complex_averager_ema.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_complex_averager_ema.sv
// Streaming complex I/Q frame averager: block average over 2^k frames or EMA,
// accumulated point-by-point in an internal RAM, with a 2-entry output FIFO.

module axis_cavg_lane #(
   parameter int HW    = 16,
   parameter int ACC_W = 48
) (
   input  logic [HW-1:0]    x,
   input  logic [ACC_W-1:0] acc,
   input  logic [4:0]       k,
   input  logic             mode,
   input  logic             init,
   input  logic             first,
   output logic [ACC_W-1:0] acc_new,
   output logic [HW-1:0]    y
);
   logic signed [ACC_W-1:0] xe, a, n;

   always_comb begin
      xe = {{(ACC_W-HW){x[HW-1]}}, x};
      a  = acc;
      if (!mode)     n = (first ? '0 : a) + xe;
      else if (init) n = xe <<< k;
      else           n = a + xe - (a >>> k);
      acc_new = n;
      y       = HW'(n >>> k);
   end
endmodule

module axis_complex_averager_ema #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int ACC_WIDTH        = 48,
   parameter int FRAME_LOG        = 10
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [4:0]                  AV_log_count,
   input  logic                        AV_mode,
   input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                        S_AXIS_tvalid,
   output logic                        S_AXIS_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                        M_AXIS_tvalid,
   input  logic                        M_AXIS_tready,
   output logic                        M_AXIS_tlast,
   output logic                        AV_frame_done
);
   localparam int HW        = AXIS_TDATA_WIDTH / 2;
   localparam int KMAX      = ACC_WIDTH - HW - 1;
   localparam int NUM_LANES = 2;
   localparam int DEPTH     = 1 << FRAME_LOG;

   typedef struct packed {
      logic                               vld;
      logic [FRAME_LOG-1:0]               p;
      logic [NUM_LANES-1:0][HW-1:0]       x;
      logic [4:0]                         k;
      logic                               mode;
      logic                               init;
      logic                               first;
      logic                               emit;
      logic                               last;
   } s1_t;

   typedef struct packed {
      logic                        last;
      logic [AXIS_TDATA_WIDTH-1:0] data;
   } fifo_ent_t;

   logic [FRAME_LOG-1:0] p_q, p_d;
   logic [31:0]          f_q, f_d;
   logic [4:0]           k_q, k_d, k_clamp, cur_k;
   logic                 mode_q, mode_d, init_q, init_d;
   logic                 latch, cur_mode, cur_init, last_frm;
   s1_t                  s1_q, s1_d;
   fifo_ent_t            fifo_q [2];
   fifo_ent_t            fifo_d [2];
   logic                 wr_q, wr_d, rd_q, rd_d;
   logic [1:0]           cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 push, pop, s_rdy, in_hs;

   logic [NUM_LANES*ACC_WIDTH-1:0]        ram [DEPTH];
   logic [NUM_LANES-1:0][ACC_WIDTH-1:0]   rdat_q, acc_new;
   logic [NUM_LANES-1:0][HW-1:0]          y;

   // A stage-1 result that will emit already owns a FIFO slot.
   assign push  = s1_q.vld && s1_q.emit;
   assign pop   = (cnt_q != 2'd0) && M_AXIS_tready;
   assign s_rdy = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && !push);
   assign in_hs = S_AXIS_tvalid && s_rdy;

   assign S_AXIS_tready = s_rdy;
   assign M_AXIS_tvalid = (cnt_q != 2'd0);
   assign M_AXIS_tdata  = fifo_q[rd_q].data;
   assign M_AXIS_tlast  = fifo_q[rd_q].last;
   assign AV_frame_done = done_q;

   always_comb begin
      latch    = (p_q == '0) && (f_q == '0);
      k_clamp  = (int'(AV_log_count) > KMAX) ? 5'(KMAX) : AV_log_count;
      cur_k    = latch ? k_clamp : k_q;
      cur_mode = latch ? AV_mode : mode_q;
      // mode_q resets to block, so the first EMA frame after reset is an init frame.
      cur_init = latch ? (AV_mode && (!mode_q || (k_clamp != k_q))) : init_q;
      last_frm = (f_q == ((32'd1 << cur_k) - 32'd1));
      p_d      = p_q;
      f_d      = f_q;
      k_d      = k_q;
      mode_d   = mode_q;
      init_d   = init_q;
      s1_d     = s1_q;
      s1_d.vld = 1'b0;
      if (in_hs) begin
         p_d    = p_q + 1'b1;
         if (&p_q) f_d = (cur_mode || last_frm) ? '0 : f_q + 32'd1;
         k_d    = cur_k;
         mode_d = cur_mode;
         init_d = cur_init;
         s1_d   = '{vld: 1'b1, p: p_q, x: S_AXIS_tdata, k: cur_k, mode: cur_mode,
                    init: cur_init, first: (f_q == '0), emit: (cur_mode || last_frm),
                    last: &p_q};
      end
   end

   always_comb begin
      fifo_d = fifo_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      if (push) begin
         fifo_d[wr_q] = '{last: s1_q.last, data: y};
         wr_d         = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      done_d = pop && fifo_q[rd_q].last;
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      axis_cavg_lane #(.HW(HW), .ACC_W(ACC_WIDTH)) u_lane (
         .x       (s1_q.x[g]),
         .acc     (rdat_q[g]),
         .k       (s1_q.k),
         .mode    (s1_q.mode),
         .init    (s1_q.init),
         .first   (s1_q.first),
         .acc_new (acc_new[g]),
         .y       (y[g])
      );
   end

   // Stage 1 always writes back one cycle after the read, and consecutive
   // points never share an address, so read and write never collide.
   always_ff @(posedge aclk) begin
      if (in_hs)    rdat_q      <= ram[p_q];
      if (s1_q.vld) ram[s1_q.p] <= acc_new;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         p_q    <= '0;
         f_q    <= '0;
         k_q    <= '0;
         mode_q <= 1'b0;
         init_q <= 1'b0;
         s1_q   <= '0;
         for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         p_q    <= p_d;
         f_q    <= f_d;
         k_q    <= k_d;
         mode_q <= mode_d;
         init_q <= init_d;
         s1_q   <= s1_d;
         fifo_q <= fifo_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end
endmodule

// File: tb/tb_axis_complex_averager_ema.sv
// Scoreboard bench for axis_complex_averager_ema with 4-point frames and
// hand-computed expected frames.

module tb_axis_complex_averager_ema;
   localparam int W  = 32;
   localparam int FL = 2;
   localparam int NP = 1 << FL;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic [4:0]    AV_log_count = '0;
   logic          AV_mode = 1'b0;
   logic [W-1:0]  S_AXIS_tdata = '0;
   logic          S_AXIS_tvalid = 1'b0;
   logic          S_AXIS_tready;
   logic [W-1:0]  M_AXIS_tdata;
   logic          M_AXIS_tvalid;
   logic          M_AXIS_tready = 1'b1;
   logic          M_AXIS_tlast;
   logic          AV_frame_done;

   logic          rdy_force = 1'b1;
   logic          bp_on = 1'b0;
   logic          pend_chk = 1'b0;
   int            checks = 0, errors = 0;
   int            done_cnt = 0, acc_n = 0, out_n = 0, base = 0;
   logic [W:0]    exp_q [$];

   always #5 aclk = ~aclk;

   axis_complex_averager_ema #(.AXIS_TDATA_WIDTH(W), .ACC_WIDTH(48), .FRAME_LOG(FL)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .AV_log_count  (AV_log_count),
      .AV_mode       (AV_mode),
      .S_AXIS_tdata  (S_AXIS_tdata),
      .S_AXIS_tvalid (S_AXIS_tvalid),
      .S_AXIS_tready (S_AXIS_tready),
      .M_AXIS_tdata  (M_AXIS_tdata),
      .M_AXIS_tvalid (M_AXIS_tvalid),
      .M_AXIS_tready (M_AXIS_tready),
      .M_AXIS_tlast  (M_AXIS_tlast),
      .AV_frame_done (AV_frame_done)
   );

   function automatic logic [W-1:0] pk(int i, int q);
      return {16'(q), 16'(i)};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, expv);
      end
   endtask

   // Downstream ready: random 30% duty during the backpressure phase.
   always @(posedge aclk) begin
      #1;
      M_AXIS_tready = bp_on ? ($urandom_range(0, 9) < 3) : rdy_force;
   end

   always @(negedge aclk) begin
      if (!areset) begin
         if (pend_chk)
            chk("tready_rule", 64'(S_AXIS_tready), 64'((acc_n - out_n - base) < 2));
         if (M_AXIS_tvalid && M_AXIS_tready) begin
            out_n++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out got=%h expected=none", {M_AXIS_tlast, M_AXIS_tdata});
            end else begin
               chk("out", 64'({M_AXIS_tlast, M_AXIS_tdata}), 64'(exp_q.pop_front()));
            end
         end
         if (S_AXIS_tvalid && S_AXIS_tready) acc_n++;
         if (AV_frame_done) done_cnt++;
      end
   end

   task automatic send(input logic [W-1:0] d);
      int   n;
      logic ok;
      n = 0;
      ok = 1'b0;
      S_AXIS_tdata  = d;
      S_AXIS_tvalid = 1'b1;
      do begin
         @(negedge aclk);
         ok = S_AXIS_tready;
         @(posedge aclk);
         #1;
         n++;
      end while (!ok && n < 1000);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got=stalled expected=accept");
      end
      S_AXIS_tvalid = 1'b0;
   endtask

   task automatic frame_const(int i, int q);
      for (int p = 0; p < NP; p++) send(pk(i, q));
   endtask

   task automatic expect_const(int i, int q);
      for (int p = 0; p < NP; p++) exp_q.push_back({p == NP - 1, pk(i, q)});
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || M_AXIS_tvalid) && n < 2000) begin
         @(posedge aclk);
         #1;
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got=pending=%0d expected=0", exp_q.size());
      end
      repeat (3) @(posedge aclk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      @(posedge aclk);
      #1;
      chk("rst_s_tready", 64'(S_AXIS_tready), 64'd1);
      chk("rst_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
      chk("rst_m_tlast",  64'(M_AXIS_tlast),  64'd0);
      chk("rst_m_tdata",  64'(M_AXIS_tdata),  64'd0);
      chk("rst_done",     64'(AV_frame_done), 64'd0);

      // Block k=2: four identical frames average to themselves.
      AV_mode = 1'b0;
      AV_log_count = 5'd2;
      for (int p = 0; p < NP; p++) exp_q.push_back({p == NP - 1, pk(4 * p + 1, -4 * p)});
      for (int f = 0; f < 4; f++)
         for (int p = 0; p < NP; p++) send(pk(4 * p + 1, -4 * p));
      drain();
      chk("done_blk_k2", 64'(done_cnt), 64'd1);

      // Block k=1: (3 + -4) >>> 1 = -1, (2 + -5) >>> 1 = -2 (floor).
      AV_log_count = 5'd1;
      expect_const(-1, -2);
      frame_const(3, 2);
      frame_const(-4, -5);
      drain();
      chk("done_blk_k1", 64'(done_cnt), 64'd2);

      // EMA k=2: steady 100/-100, then step to 0 -> I 75,56,42 and Q -75,-57,-42.
      AV_mode = 1'b1;
      AV_log_count = 5'd2;
      repeat (3) expect_const(100, -100);
      expect_const(75, -75);
      expect_const(56, -57);
      expect_const(42, -42);
      repeat (3) frame_const(100, -100);
      repeat (3) frame_const(0, 0);
      drain();
      chk("done_ema", 64'(done_cnt), 64'd8);

      // Block k=0 under random backpressure: output equals input.
      AV_mode = 1'b0;
      AV_log_count = 5'd0;
      base = acc_n - out_n;
      bp_on = 1'b1;
      pend_chk = 1'b1;
      for (int f = 0; f < 5; f++)
         for (int p = 0; p < NP; p++)
            exp_q.push_back({p == NP - 1, pk(f * 16 + p + 1, -(f * 16 + p) * 3 - 1)});
      for (int f = 0; f < 5; f++)
         for (int p = 0; p < NP; p++) send(pk(f * 16 + p + 1, -(f * 16 + p) * 3 - 1));
      pend_chk = 1'b0;
      bp_on = 1'b0;
      drain();
      chk("done_bp", 64'(done_cnt), 64'd13);

      // k changed 3 -> 1 mid-run: full 8-frame run, then 2-frame runs.
      AV_log_count = 5'd3;
      expect_const(10, -4);
      expect_const(7, -1);
      for (int f = 0; f < 8; f++) begin
         if (f == 2) AV_log_count = 5'd1;
         if (f % 2 == 0) frame_const(9, -3);
         else            frame_const(11, -5);
      end
      frame_const(7, 1);
      frame_const(8, -2);
      drain();
      chk("done_kchg", 64'(done_cnt), 64'd15);

      // Async reset mid-frame with two results pending.
      AV_log_count = 5'd0;
      rdy_force = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      send(pk(1, 1));
      send(pk(2, 2));
      repeat (2) @(posedge aclk);
      #1;
      chk("pend_before_rst", 64'(M_AXIS_tvalid), 64'd1);
      #2 areset = 1'b1;
      #1;
      chk("rst_mid_tvalid", 64'(M_AXIS_tvalid), 64'd0);
      chk("rst_mid_tready", 64'(S_AXIS_tready), 64'd1);
      #3 areset = 1'b0;
      @(posedge aclk);
      #1;
      rdy_force = 1'b1;
      expect_const(5, -6);
      frame_const(5, -6);
      drain();
      chk("done_after_rst", 64'(done_cnt), 64'd16);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
